// File: rtl/sgd_run_ctrl.sv
// Run controller and dataset-RAM arbiter for the SGD regression engine.
// The host owns the RAM while idle; the engine reads it (bounds-checked) during a run.
module sgd_run_ctrl #(
  parameter int ADDR_WIDTH   = 12,
  parameter int LENGTH       = 16,
  parameter int MAX_FEATURES = 15,
  parameter int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  host_wr_en,
  input  logic [ADDR_WIDTH-1:0] host_wr_addr,
  input  logic [DATA_WIDTH-1:0] host_wr_data,
  output logic                  host_wr_ready,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] n_points,
  input  logic [7:0]            n_epochs,
  output logic                  eng_start,
  output logic                  eng_rst,
  input  logic                  eng_req,
  input  logic [ADDR_WIDTH-1:0] eng_addr,
  output logic                  eng_gnt,
  output logic [DATA_WIDTH-1:0] eng_rdata,
  output logic                  eng_rvalid,
  input  logic                  eng_done,
  input  logic [DATA_WIDTH-1:0] eng_weights,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] weights,
  output logic                  err_cfg,
  output logic                  err_oor,
  output logic [15:0]           rd_count
);

  typedef enum logic [1:0] {S_IDLE, S_KICK, S_RUN, S_CAPTURE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_launch;
  logic                  w_cfg_bad;
  logic                  w_oor;
  logic                  w_gnt;
  logic                  w_hit;
  logic                  r_rd_hit;
  logic [ADDR_WIDTH-1:0] r_n_points;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_oor = (eng_addr > r_n_points);
  assign w_gnt = (r_state == S_RUN) && eng_req;
  assign w_hit = w_gnt && !w_oor;

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_cfg_bad   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (n_points == '0 || n_epochs == 8'd0) begin
            w_cfg_bad = 1'b1;
          end else begin
            w_launch    = 1'b1;
            w_state_nxt = S_KICK;
          end
        end
      end
      S_KICK:    w_state_nxt = abort ? S_IDLE : S_RUN;
      // abort outranks a simultaneous eng_done
      S_RUN: begin
        if (abort)         w_state_nxt = S_IDLE;
        else if (eng_done) w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    host_wr_ready = (r_state == S_IDLE);
    eng_gnt       = w_gnt;
    ram_we        = (r_state == S_IDLE) && host_wr_en;
    ram_en        = ram_we || w_hit;
    ram_addr      = (r_state == S_IDLE) ? host_wr_addr : eng_addr;
    ram_wdata     = host_wr_data;
  end

  // RAM data arrives one cycle after the grant; out-of-range reads return zero
  assign eng_rdata = r_rd_hit ? ram_rdata : '0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      eng_start  <= 1'b0;
      eng_rst    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      weights    <= '0;
      err_cfg    <= 1'b0;
      err_oor    <= 1'b0;
      rd_count   <= 16'd0;
      eng_rvalid <= 1'b0;
      r_rd_hit   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      eng_start  <= w_launch;
      eng_rst    <= abort && (r_state == S_KICK || r_state == S_RUN);
      busy       <= (w_state_nxt == S_KICK) || (w_state_nxt == S_RUN);
      eng_rvalid <= w_gnt;
      r_rd_hit   <= w_hit;
      if (w_cfg_bad) err_cfg <= 1'b1;
      if (w_launch) begin
        done     <= 1'b0;
        err_oor  <= 1'b0;
        rd_count <= 16'd0;
      end
      if (w_gnt && w_oor) err_oor <= 1'b1;
      if (w_hit) rd_count <= sat_inc(rd_count);
      if (r_state == S_CAPTURE) begin
        done    <= 1'b1;
        weights <= eng_weights;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_launch) r_n_points <= n_points;
  end

endmodule

// File: tb/tb_sgd_run_ctrl.sv
// Directed bench for sgd_run_ctrl: table-driven engine read run plus
// hand-written sequences for config error, out-of-range, abort and reset.
module tb_sgd_run_ctrl;
  localparam int AW = 12;
  localparam int DW = 256;

  logic          CLK;
  logic          RST;
  logic          host_wr_en;
  logic [AW-1:0] host_wr_addr;
  logic [DW-1:0] host_wr_data;
  logic          host_wr_ready;
  logic          start, abort;
  logic [AW-1:0] n_points;
  logic [7:0]    n_epochs;
  logic          eng_start, eng_rst;
  logic          eng_req;
  logic [AW-1:0] eng_addr;
  logic          eng_gnt;
  logic [DW-1:0] eng_rdata;
  logic          eng_rvalid;
  logic          eng_done;
  logic [DW-1:0] eng_weights;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          busy, done;
  logic [DW-1:0] weights;
  logic          err_cfg, err_oor;
  logic [15:0]   rd_count;

  sgd_run_ctrl dut (
    .CLK(CLK), .RST(RST),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_wr_ready(host_wr_ready),
    .start(start), .abort(abort), .n_points(n_points), .n_epochs(n_epochs),
    .eng_start(eng_start), .eng_rst(eng_rst),
    .eng_req(eng_req), .eng_addr(eng_addr), .eng_gnt(eng_gnt),
    .eng_rdata(eng_rdata), .eng_rvalid(eng_rvalid),
    .eng_done(eng_done), .eng_weights(eng_weights),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .busy(busy), .done(done), .weights(weights),
    .err_cfg(err_cfg), .err_oor(err_oor), .rd_count(rd_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single-port RAM model, one-cycle read latency
  logic [DW-1:0] mem [0:15];
  always @(posedge CLK) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr[3:0]] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr[3:0]];
    end
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic          host_wr;
    logic          done_in;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vt [0:9];
  int   n_vec;
  int   n_fail;
  logic [DW-1:0] W1, W2, W3;

  function automatic logic [DW-1:0] pat(input int a);
    logic [DW-1:0] r;
    for (int k = 0; k < 16; k++) r[k*16 +: 16] = 16'hA000 + 16'(a * 16 + k);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int reads [0:9];
    reads = '{0, 1, 2, 3, 1, 2, 3, 1, 2, 3};
    n_vec = 0;
    n_fail = 0;
    W1 = {8{32'hDEADBEEF}};
    W2 = {8{32'h0BADF00D}};
    W3 = {8{32'h13572468}};
    for (int i = 0; i < 10; i++) begin
      vt[i].addr      = AW'(reads[i]);
      vt[i].host_wr   = (i == 4);
      vt[i].done_in   = (i == 9);
      vt[i].exp_rdata = pat(reads[i]);
    end

    RST = 1'b1; host_wr_en = 0; host_wr_addr = '0; host_wr_data = '0;
    start = 0; abort = 0; n_points = '0; n_epochs = '0;
    eng_req = 0; eng_addr = '0; eng_done = 0; eng_weights = W1;
    tick; tick;
    chk("rst_busy", busy, 0);          chk("rst_done", done, 0);
    chk("rst_weights", weights, 0);    chk("rst_err_cfg", err_cfg, 0);
    chk("rst_err_oor", err_oor, 0);    chk("rst_rd_count", rd_count, 0);
    chk("rst_rvalid", eng_rvalid, 0);  chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_rst", eng_rst, 0);    chk("rst_host_ready", host_wr_ready, 1);
    RST = 1'b0;

    // Load weights and points; the last write shares its cycle with start
    for (int a = 0; a < 4; a++) begin
      host_wr_en = 1; host_wr_addr = AW'(a); host_wr_data = pat(a);
      if (a == 3) begin start = 1; n_points = 3; n_epochs = 2; end
      #1;
      chk("load_ready", host_wr_ready, 1);
      chk("load_ram_we", ram_we, 1);
      chk("load_ram_en", ram_en, 1);
      tick;
    end
    chk("kick_eng_start", eng_start, 1);
    chk("kick_busy", busy, 1);
    start = 0; host_wr_en = 0;
    #1;
    chk("kick_host_ready", host_wr_ready, 0);
    chk("kick_gnt_quiet", eng_gnt, 0);
    tick;
    chk("run_eng_start_low", eng_start, 0);
    chk("run_busy", busy, 1);

    // Pipelined engine reads from the table
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) begin
        chk("tbl_rvalid", eng_rvalid, 1);
        chk("tbl_rdata", eng_rdata, vt[i-1].exp_rdata);
      end
      if (i < 10) begin
        eng_req = 1; eng_addr = vt[i].addr; eng_done = vt[i].done_in;
        host_wr_en = vt[i].host_wr; host_wr_addr = 1; host_wr_data = '1;
        #1;
        chk("tbl_gnt", eng_gnt, 1);
        chk("tbl_ram_en", ram_en, 1);
        chk("tbl_ram_we", ram_we, 0);
        chk("tbl_ram_addr", ram_addr, vt[i].addr);
        if (vt[i].host_wr) chk("tbl_host_blocked", host_wr_ready, 0);
        tick;
      end else begin
        eng_req = 0; eng_done = 0; host_wr_en = 0;
      end
    end
    chk("cap_busy", busy, 0);
    chk("cap_done_not_yet", done, 0);
    chk("cap_rd_count", rd_count, 10);
    tick;
    chk("done_set", done, 1);
    chk("done_weights", weights, W1);
    chk("done_host_ready", host_wr_ready, 1);
    chk("ram_addr1_intact", mem[1], pat(1));

    // Refused start: zero data points
    start = 1; n_points = 0; n_epochs = 2;
    tick;
    start = 0;
    chk("cfg_err", err_cfg, 1);
    chk("cfg_no_start", eng_start, 0);
    chk("cfg_busy", busy, 0);
    chk("cfg_idle", host_wr_ready, 1);
    chk("cfg_done_kept", done, 1);

    // Out-of-range read, then boundary read, then abort with eng_done
    start = 1; n_points = 3; n_epochs = 1; eng_weights = W2;
    tick;
    start = 0;
    chk("oor_done_cleared", done, 0);
    chk("oor_err_cfg_sticky", err_cfg, 1);
    tick;
    eng_req = 1; eng_addr = 5;
    #1;
    chk("oor_gnt", eng_gnt, 1);
    chk("oor_no_ram_en", ram_en, 0);
    tick;
    chk("oor_rvalid", eng_rvalid, 1);
    chk("oor_rdata_zero", eng_rdata, 0);
    chk("oor_err", err_oor, 1);
    eng_addr = 3;
    #1;
    chk("edge_ram_en", ram_en, 1);
    tick;
    chk("edge_rdata", eng_rdata, pat(3));
    eng_addr = 2; abort = 1; eng_done = 1;
    tick;
    eng_req = 0; abort = 0; eng_done = 0;
    chk("abort_eng_rst", eng_rst, 1);
    chk("abort_done", done, 0);
    chk("abort_weights", weights, W1);
    chk("abort_busy", busy, 0);
    chk("abort_rvalid", eng_rvalid, 1);
    chk("abort_rdata", eng_rdata, pat(2));
    chk("abort_idle", host_wr_ready, 1);
    eng_done = 1;
    tick;
    eng_done = 0;
    chk("abort_rst_pulse", eng_rst, 0);
    tick;
    chk("stray_done_ignored", done, 0);

    // Reset while a read is in flight
    start = 1; n_points = 3; n_epochs = 1;
    tick;
    start = 0;
    tick;
    eng_req = 1; eng_addr = 1; RST = 1;
    tick;
    eng_req = 0; RST = 0;
    chk("mid_rst_rvalid", eng_rvalid, 0);
    chk("mid_rst_rdata", eng_rdata, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err_oor", err_oor, 0);
    chk("mid_rst_err_cfg", err_cfg, 0);
    chk("mid_rst_weights", weights, 0);
    chk("mid_rst_rd_count", rd_count, 0);
    chk("mid_rst_host_ready", host_wr_ready, 1);

    // Fresh run after reset
    start = 1; n_points = 2; n_epochs = 1; eng_weights = W3;
    tick;
    start = 0;
    chk("rerun_eng_start", eng_start, 1);
    chk("rerun_busy", busy, 1);
    tick;
    eng_req = 1; eng_addr = 2; eng_done = 1;
    tick;
    eng_req = 0; eng_done = 0;
    chk("rerun_rdata", eng_rdata, pat(2));
    chk("rerun_rd_count", rd_count, 1);
    tick;
    chk("rerun_done", done, 1);
    chk("rerun_weights", weights, W3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
